// File: rtl/alu_console.sv
// alu_console: hex-key operand/function entry console for an external ALU.
// Rev 1.0 - initial release.
`default_nettype none

module alu_console #(
  parameter int WIDTH = 32,
  parameter int FW    = 3,
  parameter int TW    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      sw,
  input  logic             cl_p,
  input  logic             cr_p,
  input  logic             bs_p,
  input  logic             clr_p,
  input  logic             ans_p,
  input  logic [WIDTH-1:0] y,
  input  logic [TW-1:0]    t,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [FW-1:0]    f,
  output logic [TW-1:0]    t_q,
  output logic [3:0]       state,
  output logic [WIDTH-1:0] disp
);

  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_F = 2'd2,
    S_Y = 2'd3
  } state_t;

  state_t           r_state;
  logic [15:0]      r_sw_q;
  logic             r_primed;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [FW-1:0]    r_f;
  logic [TW-1:0]    r_t_q;

  logic [15:0]      w_diff;
  logic [3:0]       w_digit;
  logic             w_evt;

  // Scan from the top so the lowest changed bit wins.
  always_comb begin
    w_diff  = sw ^ r_sw_q;
    w_digit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_diff[i]) w_digit = 4'(i);
    end
    w_evt = r_primed && (|w_diff) && (r_state != S_Y);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_A;
      r_sw_q   <= 16'd0;
      r_primed <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= '0;
      r_t_q    <= '0;
    end else begin
      r_sw_q   <= sw;
      r_primed <= 1'b1;
      r_t_q    <= t;

      if (cr_p && !cl_p) begin
        unique case (r_state)
          S_A: r_state <= S_B;
          S_B: r_state <= S_F;
          S_F: r_state <= S_Y;
          S_Y: r_state <= S_A;
        endcase
      end else if (cl_p && !cr_p) begin
        unique case (r_state)
          S_A: r_state <= S_Y;
          S_B: r_state <= S_A;
          S_F: r_state <= S_B;
          S_Y: r_state <= S_F;
        endcase
      end

      // Edits act on the field selected before any navigation this cycle.
      if (ans_p) begin
        r_a <= y;
      end else if (r_state == S_A) begin
        if (clr_p)      r_a <= '0;
        else if (bs_p)  r_a <= r_a >> 4;
        else if (w_evt) r_a <= {r_a[WIDTH-5:0], w_digit};
      end

      if (r_state == S_B) begin
        if (clr_p)      r_b <= '0;
        else if (bs_p)  r_b <= r_b >> 4;
        else if (w_evt) r_b <= {r_b[WIDTH-5:0], w_digit};
      end

      if (r_state == S_F) begin
        if (clr_p || bs_p) r_f <= '0;
        else if (w_evt)    r_f <= w_digit[FW-1:0];
      end
    end
  end

  always_comb begin
    disp  = '0;
    state = 4'b0001;
    unique case (r_state)
      S_A: begin disp = r_a; state = 4'b0001; end
      S_B: begin disp = r_b; state = 4'b0010; end
      S_F: begin disp = {{(WIDTH-FW){1'b0}}, r_f}; state = 4'b0100; end
      S_Y: begin disp = y;   state = 4'b1000; end
    endcase
  end

  assign a   = r_a;
  assign b   = r_b;
  assign f   = r_f;
  assign t_q = r_t_q;

endmodule

`default_nettype wire
